// File: rtl/out_display_if.sv
// rtl/out_display_if.sv - value/load input and display pin bundle for out_display
interface out_display_if;
  logic [7:0] i_value;
  logic       i_load;
  logic [6:0] o_seg;
  logic       o_dp;
  logic [3:0] o_an;
  logic       o_busy;

  modport master (output i_value, i_load, input o_seg, o_dp, o_an, o_busy);
  modport slave  (input i_value, i_load, output o_seg, o_dp, o_an, o_busy);
endinterface

// File: rtl/out_display.sv
// rtl/out_display.sv - latches an 8-bit value, converts it with double dabble and
// drives a 4-digit multiplexed common-anode 7-segment display
module out_display #(
  parameter int REFRESH_DIV = 1024,
  parameter int SIGNED_MODE = 0
) (
  input logic         i_clk,
  input logic         i_rst,
  out_display_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

  localparam logic [15:0] REFRESH_TC = 16'(REFRESH_DIV - 1);
  localparam logic [6:0]  SEG_MINUS  = 7'b0111111;
  localparam logic [6:0]  SEG_BLANK  = 7'b1111111;

  state_t      state;
  logic [7:0]  bin;
  logic [11:0] bcd;
  logic [2:0]  bit_cnt;
  logic        work_neg;
  logic        pend;
  logic [7:0]  pend_mag;
  logic        pend_neg;
  logic [3:0]  disp_h, disp_t, disp_o;
  logic        disp_neg;
  logic [15:0] refresh_cnt;
  logic [1:0]  idx;

  logic        in_neg;
  logic [7:0]  in_mag;

  always_comb begin
    in_neg = (SIGNED_MODE != 0) && bus.i_value[7];
    in_mag = in_neg ? (~bus.i_value + 8'd1) : bus.i_value;
  end

  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int n = 0; n < 3; n++) begin
      if (b[n*4 +: 4] >= 4'd5) r[n*4 +: 4] = b[n*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      bin      <= '0;
      bcd      <= '0;
      bit_cnt  <= '0;
      work_neg <= 1'b0;
      pend     <= 1'b0;
      pend_mag <= '0;
      pend_neg <= 1'b0;
      disp_h   <= '0;
      disp_t   <= '0;
      disp_o   <= '0;
      disp_neg <= 1'b0;
    end else begin
      // A load that cannot be taken right now is queued, last one wins
      if (bus.i_load && state != IDLE) begin
        pend     <= 1'b1;
        pend_mag <= in_mag;
        pend_neg <= in_neg;
      end
      case (state)
        IDLE: begin
          if (pend || bus.i_load) begin
            bin      <= pend ? pend_mag : in_mag;
            work_neg <= pend ? pend_neg : in_neg;
            bcd      <= '0;
            bit_cnt  <= '0;
            state    <= CONV;
            // A load arriving while the pending value starts is re-queued, not lost
            pend     <= pend && bus.i_load;
            if (pend && bus.i_load) begin
              pend_mag <= in_mag;
              pend_neg <= in_neg;
            end
          end
        end
        CONV: begin
          {bcd, bin} <= {add3(bcd), bin} << 1;
          bit_cnt    <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= LATCH;
        end
        LATCH: begin
          disp_h   <= bcd[11:8];
          disp_t   <= bcd[7:4];
          disp_o   <= bcd[3:0];
          disp_neg <= work_neg;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      refresh_cnt <= '0;
      idx         <= '0;
    end else if (refresh_cnt == REFRESH_TC) begin
      refresh_cnt <= '0;
      idx         <= idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 16'd1;
    end
  end

  logic [6:0] seg_mux;

  always_comb begin
    seg_mux = SEG_BLANK;
    case (idx)
      2'd3: seg_mux = disp_neg ? SEG_MINUS : SEG_BLANK;
      2'd2: seg_mux = (disp_h == 4'd0) ? SEG_BLANK : glyph(disp_h);
      2'd1: seg_mux = (disp_h == 4'd0 && disp_t == 4'd0) ? SEG_BLANK : glyph(disp_t);
      default: seg_mux = glyph(disp_o);
    endcase
  end

  assign bus.o_seg  = seg_mux;
  assign bus.o_an   = ~(4'b0001 << idx);
  assign bus.o_dp   = 1'b1;
  assign bus.o_busy = (state != IDLE) || pend;
endmodule
